cnn_request_arbiter: RTL

CNN_REQUEST_ARBITER -- requirements
Module: cnn_request_arbiter

---
 rtl/cnn_request_arbiter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/cnn_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cnn_request_arbiter
// Purpose  : Round-robin arbiter that shares one CNN accelerator engine among
//            NUM_REQ requesters. One job in flight at a time: accept, start
//            the engine, wait for done (or time out), return the result to the
//            owning requester, then pulse the engine reset before re-arming.
// Ports    : clk, resetn (async, active-low)
//            req_valid/req_image_index  -> per-requester job requests
//            req_ready                  <- one-hot accept pulse
//            resp_valid/resp_class/resp_timeout <- per-job result
//            eng_start/eng_image_index/eng_resetn -> engine control
//            eng_predicted_class/eng_done         <- engine result
//            busy, jobs_done (wrapping), timeouts (saturating) <- status
// Revision : 1.0 - initial release
// ============================================================================
module cnn_request_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [5*NUM_REQ-1:0]   req_image_index,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [3:0]             resp_class,
    output logic                   resp_timeout,
    output logic                   eng_start,
    output logic [4:0]             eng_image_index,
    input  logic [3:0]             eng_predicted_class,
    input  logic                   eng_done,
    output logic                   eng_resetn,
    output logic                   busy,
    output logic [15:0]            jobs_done,
    output logic [7:0]             timeouts
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RC_W  = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    localparam logic [TMR_W-1:0] TIMER_LIMIT = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [RC_W-1:0]  RC_LAST     = RC_W'(RECOVER_CYCLES - 1);
    localparam logic [ID_W-1:0]  LAST_ID     = ID_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_DONE = 3'd2,
        RESPOND   = 3'd3,
        RECOVER   = 3'd4
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   owner;
    logic [ID_W-1:0]   cand;
    logic [ID_W-1:0]   pick_id;
    logic              pick_found;
    logic [4:0]        pick_index;
    logic [4:0]        job_index;
    logic [TMR_W-1:0]  timer;
    logic [RC_W-1:0]   rec_cnt;
    logic              expired;
    logic              in_recover;

    // Round-robin search starting one past the previous winner.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_comb begin
        pick_index = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (pick_id == ID_W'(r)) begin
                pick_index = req_image_index[5*r +: 5];
            end
        end
    end

    // The timer holds the number of WAIT_DONE cycles already spent, so the
    // job is abandoned TIMEOUT_CYCLES+2 cycles after eng_start. A done seen
    // in the expiry cycle still counts as success.
    assign expired = (timer == TIMER_LIMIT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        eng_start       = 1'b0;
        resp_valid      = '0;
        busy            = 1'b1;
        eng_image_index = job_index;
        in_recover      = 1'b0;
        case (state)
            IDLE: begin
                busy            = 1'b0;
                eng_image_index = '0;
                if (pick_found) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                eng_start  = 1'b1;
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (eng_done || expired) begin
                    state_next = RESPOND;
                end
            end
            RESPOND: begin
                resp_valid = NUM_REQ'(1) << owner;
                state_next = RECOVER;
            end
            RECOVER: begin
                in_recover = 1'b1;
                if (rec_cnt == RC_LAST) begin
                    state_next = IDLE;
                end
            end
            default: begin
                busy            = 1'b0;
                eng_image_index = '0;
                state_next      = IDLE;
            end
        endcase
    end

    // Engine reset follows the system reset immediately, plus the recovery window.
    assign eng_resetn = resetn & ~in_recover;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_ready    <= '0;
            owner        <= '0;
            job_index    <= '0;
            last_grant   <= LAST_ID;
            timer        <= '0;
            rec_cnt      <= '0;
            resp_class   <= '0;
            resp_timeout <= 1'b0;
            jobs_done    <= '0;
            timeouts     <= '0;
        end else begin
            req_ready <= '0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        req_ready <= NUM_REQ'(1) << pick_id;
                        owner     <= pick_id;
                        job_index <= pick_index;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                end
                WAIT_DONE: begin
                    timer <= timer + TMR_W'(1);
                    if (eng_done) begin
                        resp_class   <= eng_predicted_class;
                        resp_timeout <= 1'b0;
                    end else if (expired) begin
                        resp_class   <= '0;
                        resp_timeout <= 1'b1;
                    end
                end
                RESPOND: begin
                    rec_cnt <= '0;
                    if (resp_timeout) begin
                        if (timeouts != 8'hFF) begin
                            timeouts <= timeouts + 8'd1;
                        end
                    end else begin
                        jobs_done <= jobs_done + 16'd1;
                    end
                end
                RECOVER: begin
                    rec_cnt <= rec_cnt + RC_W'(1);
                    if (rec_cnt == RC_LAST) begin
                        last_grant <= owner;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
